video_timing_generator: RTL and testbench

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_generator.sv | 108 ++++++++++
 tb/tb_video_timing_generator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// Raster timing generator: pixel/line counters with registered sync and blank flags.
// Ports: clk, reset_n, pix_en in; hpos, vpos, syncs, blanks, start pulses, frame_cnt out.
module video_timing_generator #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CW        = 9,
  parameter int FW        = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          hblank,
  output logic          vblank,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int HS_BEG  = H_DISPLAY + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG  = V_DISPLAY + V_BOTTOM;
  localparam int VS_END  = VS_BEG + V_SYNC - 1;
  localparam int MAX_T   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  if ((64'd1 << CW) < 64'(MAX_T)) begin : g_bad_cw
    $error("CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_DISPLAY == 0 || H_SYNC == 0 ||
      V_DISPLAY == 0 || V_SYNC == 0) begin : g_bad_len
    $error("display and sync lengths must be nonzero");
  end

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          hb_nxt;
  logic          vb_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  // Flags are derived from the next counter values so that the
  // registered flags line up with the registered counters.
  always_comb begin
    h_last = (hpos == CW'(H_TOTAL - 1));
    v_last = (vpos == CW'(V_TOTAL - 1));
    h_nxt  = h_last ? '0 : hpos + 1'b1;
    v_nxt  = vpos;
    if (h_last) begin
      v_nxt = v_last ? '0 : vpos + 1'b1;
    end
    hb_nxt = (h_nxt >= CW'(H_DISPLAY));
    vb_nxt = (v_nxt >= CW'(V_DISPLAY));
    hs_nxt = (h_nxt >= CW'(HS_BEG)) &&
             (h_nxt <= CW'(HS_END));
    vs_nxt = (v_nxt >= CW'(VS_BEG)) &&
             (v_nxt <= CW'(VS_END));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      display_on  <= 1'b1;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      // Pulses last one clk even if pix_en stays low afterwards.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hpos        <= h_nxt;
        vpos        <= v_nxt;
        hsync       <= hs_nxt ? HSYNC_POL : ~HSYNC_POL;
        vsync       <= vs_nxt ? VSYNC_POL : ~VSYNC_POL;
        hblank      <= hb_nxt;
        vblank      <= vb_nxt;
        display_on  <= ~hb_nxt & ~vb_nxt;
        line_start  <= h_last;
        frame_start <= h_last & v_last;
        if (h_last && v_last) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_generator.sv
// Bench for video_timing_generator: default instance plus a small
// low-polarity instance, scoreboard queues checked by monitor processes.
module tb_video_timing_generator;

  localparam int AHT = 309;
  localparam int AVT = 262;
  localparam int BHT = 8;
  localparam int BVT = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn_a, pe_a, rn_b, pe_b;
  logic [8:0] hp_a, vp_a;
  logic [7:0] fc_a;
  logic       hs_a, vs_a, de_a, hb_a, vb_a, ls_a, fs_a;
  logic [2:0] hp_b, vp_b;
  logic [1:0] fc_b;
  logic       hs_b, vs_b, de_b, hb_b, vb_b, ls_b, fs_b;

  video_timing_generator u_a (
    .clk(clk), .reset_n(rn_a), .pix_en(pe_a),
    .hpos(hp_a), .vpos(vp_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .hblank(hb_a), .vblank(vb_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  video_timing_generator #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(3), .FW(2)
  ) u_b (
    .clk(clk), .reset_n(rn_b), .pix_en(pe_b),
    .hpos(hp_b), .vpos(vp_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .hblank(hb_b), .vblank(vb_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  typedef struct packed {
    int h; int v; int fc;
    bit hs; bit vs; bit de; bit hb; bit vb; bit ls; bit fs;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ma, mb;
  int   vectors = 0;
  int   miscompares = 0;
  event probe;

  int n_ls_a, n_fs_a, n_hs0_a, n_vsl_a, first_de0_a, first_vs_a;
  int fcq_b[$];

  function automatic exp_t rst0();
    exp_t m;
    m = '0;
    return m;
  endfunction

  // Hand-derived decode for the default timing (H 309, V 262).
  function automatic exp_t mk_a(exp_t m);
    m.hb = (m.h >= 256);
    m.vb = (m.v >= 240);
    m.de = !m.hb && !m.vb;
    m.hs = (m.h >= 263) && (m.h <= 285);
    m.vs = (m.v >= 254) && (m.v <= 256);
    return m;
  endfunction

  // Small timing: H 4+1+2+1, V 3+1+1+1, both syncs active-low.
  function automatic exp_t mk_b(exp_t m);
    m.hb = (m.h >= 4);
    m.vb = (m.v >= 3);
    m.de = !m.hb && !m.vb;
    m.hs = !((m.h == 5) || (m.h == 6));
    m.vs = !(m.v == 4);
    return m;
  endfunction

  function automatic exp_t adv(exp_t m, bit pe, int ht, int vt, int fmod);
    m.ls = 1'b0;
    m.fs = 1'b0;
    if (pe) begin
      if (m.h == ht - 1) begin
        m.h  = 0;
        m.ls = 1'b1;
        if (m.v == vt - 1) begin
          m.v  = 0;
          m.fs = 1'b1;
          m.fc = (m.fc + 1) % fmod;
        end else begin
          m.v = m.v + 1;
        end
      end else begin
        m.h = m.h + 1;
      end
    end
    return m;
  endfunction

  task automatic check(string nm, int got, int exp_v);
    vectors++;
    if (got != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
    end
  endtask

  task automatic chk_a();
    exp_t e;
    if (qa.size() == 0) return;
    e = qa.pop_front();
    vectors++;
    if (hp_a !== 9'(e.h) || vp_a !== 9'(e.v) || fc_a !== 8'(e.fc) ||
        hs_a !== e.hs || vs_a !== e.vs || de_a !== e.de ||
        hb_a !== e.hb || vb_a !== e.vb || ls_a !== e.ls ||
        fs_a !== e.fs) begin
      miscompares++;
      $display("FAIL dut_a t=%0t got h=%0d v=%0d fc=%0d hs%b vs%b de%b hb%b vb%b ls%b fs%b exp h=%0d v=%0d fc=%0d hs%b vs%b de%b hb%b vb%b ls%b fs%b",
               $time, hp_a, vp_a, fc_a, hs_a, vs_a, de_a, hb_a, vb_a,
               ls_a, fs_a, e.h, e.v, e.fc, e.hs, e.vs, e.de, e.hb,
               e.vb, e.ls, e.fs);
    end
    if (ls_a === 1'b1) n_ls_a++;
    if (fs_a === 1'b1) n_fs_a++;
    if (hs_a === 1'b1 && vp_a == 9'd0) n_hs0_a++;
    if (ls_a === 1'b1 && vs_a === 1'b1) n_vsl_a++;
    if (vp_a == 9'd0 && de_a === 1'b0 && int'(hp_a) < first_de0_a)
      first_de0_a = int'(hp_a);
    if (vs_a === 1'b1 && int'(vp_a) < first_vs_a)
      first_vs_a = int'(vp_a);
  endtask

  task automatic chk_b();
    exp_t e;
    if (qb.size() == 0) return;
    e = qb.pop_front();
    vectors++;
    if (hp_b !== 3'(e.h) || vp_b !== 3'(e.v) || fc_b !== 2'(e.fc) ||
        hs_b !== e.hs || vs_b !== e.vs || de_b !== e.de ||
        hb_b !== e.hb || vb_b !== e.vb || ls_b !== e.ls ||
        fs_b !== e.fs) begin
      miscompares++;
      $display("FAIL dut_b t=%0t got h=%0d v=%0d fc=%0d hs%b vs%b de%b hb%b vb%b ls%b fs%b exp h=%0d v=%0d fc=%0d hs%b vs%b de%b hb%b vb%b ls%b fs%b",
               $time, hp_b, vp_b, fc_b, hs_b, vs_b, de_b, hb_b, vb_b,
               ls_b, fs_b, e.h, e.v, e.fc, e.hs, e.vs, e.de, e.hb,
               e.vb, e.ls, e.fs);
    end
    if (fs_b === 1'b1) fcq_b.push_back(int'(fc_b));
  endtask

  always @(negedge clk) begin
    chk_a();
    chk_b();
  end

  always @(probe) begin
    chk_a();
    chk_b();
  end

  task automatic clr_a();
    n_ls_a = 0; n_fs_a = 0; n_hs0_a = 0; n_vsl_a = 0;
    first_de0_a = 999; first_vs_a = 999;
  endtask

  task automatic step_a(bit pe);
    pe_a = pe;
    @(posedge clk);
    #1;
    ma = mk_a(adv(ma, pe, AHT, AVT, 256));
    qa.push_back(ma);
  endtask

  task automatic step_b(bit pe);
    pe_b = pe;
    @(posedge clk);
    #1;
    mb = mk_b(adv(mb, pe, BHT, BVT, 4));
    qb.push_back(mb);
  endtask

  // Assert reset between edges and check before the next rising edge.
  task automatic reset_a();
    @(negedge clk);
    #2;
    rn_a = 1'b0;
    ma = mk_a(rst0());
    #1;
    qa.push_back(ma);
    -> probe;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rn_a = 1'b1;
    clr_a();
  endtask

  task automatic reset_b();
    @(negedge clk);
    #2;
    rn_b = 1'b0;
    mb = mk_b(rst0());
    #1;
    qb.push_back(mb);
    -> probe;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rn_b = 1'b1;
    fcq_b.delete();
  endtask

  initial begin
    rn_a = 1'b0; pe_a = 1'b0;
    rn_b = 1'b0; pe_b = 1'b0;
    ma = mk_a(rst0());
    mb = mk_b(rst0());
    clr_a();
    repeat (3) @(posedge clk);
    #3;
    qa.push_back(ma);
    qb.push_back(mb);
    -> probe;
    @(negedge clk);
    #1;
    rn_a = 1'b1;
    rn_b = 1'b1;

    // Release gives no pulse; first enabled edge gives hpos 1.
    step_a(1'b0);
    step_a(1'b1);
    for (int i = 0; i < 12; i++)
      step_a(!(i % 4 == 1 || i % 4 == 2));
    while (ma.h != 150) step_a(1'b1);
    reset_a();
    step_a(1'b0);
    step_a(1'b1);

    // Wrap with pix_en 1,1,0,0,1: hpos sits at 0 for three clks.
    while (ma.h != 307) step_a(1'b1);
    step_a(1'b1);
    step_a(1'b1);
    step_a(1'b0);
    step_a(1'b0);
    step_a(1'b1);

    // One full frame from a clean reset.
    reset_a();
    repeat (AHT * AVT) step_a(1'b1);
    pe_a = 1'b0;
    @(negedge clk);
    #1;
    check("line_start_count", n_ls_a, 262);
    check("frame_start_count", n_fs_a, 1);
    check("frame_cnt_after_frame", int'(fc_a), 1);
    check("hsync_clks_line0", n_hs0_a, 23);
    check("first_blank_hpos", first_de0_a, 256);
    check("vsync_lines", n_vsl_a, 3);
    check("first_vsync_vpos", first_vs_a, 254);

    // Small instance: mid-frame reset, then four frames.
    step_b(1'b0);
    step_b(1'b1);
    while (!(mb.h == 3 && mb.v == 2)) step_b(1'b1);
    reset_b();
    step_b(1'b0);
    step_b(1'b1);
    repeat (BHT * BVT * 4 - 1) step_b(1'b1);
    pe_b = 1'b0;
    @(negedge clk);
    #1;
    check("b_frame_starts", fcq_b.size(), 4);
    if (fcq_b.size() == 4) begin
      check("b_fc_1", fcq_b[0], 1);
      check("b_fc_2", fcq_b[1], 2);
      check("b_fc_3", fcq_b[2], 3);
      check("b_fc_wrap", fcq_b[3], 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
